// File: rtl/fx_sched_pkg.sv
// Shared defaults and payload layout for the FX in-order issue scheduler.
package fx_sched_pkg;

  localparam int DEPTH_DEF     = 4;
  localparam int REG_W_DEF     = 5;
  localparam int PAYLOAD_W_DEF = 128;
  localparam int CNT_W_DEF     = 16;
  localparam int NUM_GPR       = 32;

  // Bit offsets inside the opaque payload; the scheduler never decodes them.
  localparam int PL_OPCODE_LSB  = 0;
  localparam int PL_OPCODE_W    = 6;
  localparam int PL_XOPCODE_LSB = 6;
  localparam int PL_XOPCODE_W   = 10;
  localparam int PL_FORMAT_LSB  = 16;
  localparam int PL_FORMAT_W    = 4;
  localparam int PL_IMM_LSB     = 20;
  localparam int PL_IMM_W       = 64;
  localparam int PL_ENABLES_LSB = 84;
  localparam int PL_ENABLES_W   = 16;
  localparam int PL_IS64_BIT    = 100;

  localparam logic [3:0] FX_UNIT_CODE = 4'h1;

endpackage

// File: rtl/fx_scoreboard.sv
// GPR busy-bit scoreboard: one set port (issue), one clear port (writeback),
// three source read ports and a destination read port.
module fx_scoreboard
  import fx_sched_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int NUM_REGS = NUM_GPR
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      set_en,
  input  logic [REG_W-1:0]          set_addr,
  input  logic                      clr_en,
  input  logic [REG_W-1:0]          clr_addr,
  input  logic [2:0][REG_W-1:0]     rd_addr,
  input  logic [REG_W-1:0]          rd_dst_addr,
  output logic [2:0]                rd_busy,
  output logic                      rd_dst_busy,
  output logic [NUM_REGS-1:0]       busy
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  // Set is tested first so a same-edge set/clear of one register leaves it busy.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
    assign busy_next[gi] = (set_en && set_addr == REG_W'(gi)) ? 1'b1 :
                           (clr_en && clr_addr == REG_W'(gi)) ? 1'b0 :
                           busy_reg[gi];
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) busy_reg <= '0;
    else          busy_reg <= busy_next;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_rd
    assign rd_busy[gi] = busy_reg[rd_addr[gi]];
  end

  assign rd_dst_busy = busy_reg[rd_dst_addr];
  assign busy        = busy_reg;

endmodule

// File: rtl/fx_issue_scheduler.sv
// In-order issue queue for the FX unit: buffers dispatched instructions and
// releases the head only when its GPR operands and destination are not busy.
module fx_issue_scheduler
  import fx_sched_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int REG_W     = REG_W_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 dispValid_i,
  output logic                 dispReady_o,
  input  logic [PAYLOAD_W-1:0] dispPayload_i,
  input  logic [REG_W-1:0]     dispSrc1_i,
  input  logic [REG_W-1:0]     dispSrc2_i,
  input  logic [REG_W-1:0]     dispSrc3_i,
  input  logic [2:0]           dispSrcEn_i,
  input  logic [REG_W-1:0]     dispDst_i,
  input  logic                 dispDstEn_i,
  output logic                 issueEnable_o,
  output logic [PAYLOAD_W-1:0] issuePayload_o,
  output logic [REG_W-1:0]     issueSrc1_o,
  output logic [REG_W-1:0]     issueSrc2_o,
  output logic [REG_W-1:0]     issueSrc3_o,
  output logic [REG_W-1:0]     issueDst_o,
  input  logic                 wbValid_i,
  input  logic [REG_W-1:0]     wbAddress_i,
  output logic [NUM_GPR-1:0]   busy_o,
  output logic [CNT_W-1:0]     stallCount_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [PTR_W:0]   count_reg;

  logic [PAYLOAD_W-1:0]     payload_mem [DEPTH];
  logic [2:0][REG_W-1:0]    src_mem     [DEPTH];
  logic [2:0]               src_en_mem  [DEPTH];
  logic [REG_W-1:0]         dst_mem     [DEPTH];
  logic                     dst_en_mem  [DEPTH];

  logic                     issue_en_reg;
  logic [PAYLOAD_W-1:0]     issue_payload_reg;
  logic [2:0][REG_W-1:0]    issue_src_reg;
  logic [REG_W-1:0]         issue_dst_reg;
  logic [CNT_W-1:0]         stall_reg;

  logic [2:0][REG_W-1:0]    disp_src;
  logic [2:0][REG_W-1:0]    head_src;
  logic [2:0]               head_src_en;
  logic [REG_W-1:0]         head_dst;
  logic                     head_dst_en;
  logic [2:0]               src_busy;
  logic                     dst_busy;
  logic                     not_empty, head_blocked, can_issue;
  logic                     disp_ready, push, pop;

  assign disp_src    = {dispSrc3_i, dispSrc2_i, dispSrc1_i};
  assign head_src    = src_mem[head_reg];
  assign head_src_en = src_en_mem[head_reg];
  assign head_dst    = dst_mem[head_reg];
  assign head_dst_en = dst_en_mem[head_reg];

  assign disp_ready   = (count_reg != (PTR_W+1)'(DEPTH));
  assign not_empty    = (count_reg != '0);
  assign head_blocked = not_empty && ((|(head_src_en & src_busy)) || (head_dst_en && dst_busy));
  assign can_issue    = not_empty && !head_blocked;
  assign push         = dispValid_i && disp_ready && !flush_i;
  assign pop          = can_issue && !flush_i;

  fx_scoreboard #(.REG_W(REG_W), .NUM_REGS(NUM_GPR)) u_scoreboard (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .set_en      (pop && head_dst_en),
    .set_addr    (head_dst),
    .clr_en      (wbValid_i),
    .clr_addr    (wbAddress_i),
    .rd_addr     (head_src),
    .rd_dst_addr (head_dst),
    .rd_busy     (src_busy),
    .rd_dst_busy (dst_busy),
    .busy        (busy_o)
  );

  // Entry storage has no reset; validity is tracked solely by count_reg.
  always_ff @(posedge clock_i) begin
    if (push) begin
      payload_mem[tail_reg] <= dispPayload_i;
      src_mem[tail_reg]     <= disp_src;
      src_en_mem[tail_reg]  <= dispSrcEn_i;
      dst_mem[tail_reg]     <= dispDst_i;
      dst_en_mem[tail_reg]  <= dispDstEn_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head_reg          <= '0;
      tail_reg          <= '0;
      count_reg         <= '0;
      issue_en_reg      <= 1'b0;
      issue_payload_reg <= '0;
      issue_src_reg     <= '0;
      issue_dst_reg     <= '0;
    end else if (flush_i) begin
      head_reg     <= tail_reg;
      count_reg    <= '0;
      issue_en_reg <= 1'b0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
      issue_en_reg <= pop;
      if (pop) begin
        issue_payload_reg <= payload_mem[head_reg];
        issue_src_reg     <= head_src;
        issue_dst_reg     <= head_dst;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i)                          stall_reg <= '0;
    else if (head_blocked && stall_reg != '1) stall_reg <= stall_reg + CNT_W'(1);
  end

  assign dispReady_o    = disp_ready;
  assign issueEnable_o  = issue_en_reg;
  assign issuePayload_o = issue_payload_reg;
  assign issueSrc1_o    = issue_src_reg[0];
  assign issueSrc2_o    = issue_src_reg[1];
  assign issueSrc3_o    = issue_src_reg[2];
  assign issueDst_o     = issue_dst_reg;
  assign stallCount_o   = stall_reg;

endmodule
